// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus types and fixed register addresses used by the sprite DMA.
package nes_bus_pkg;

  typedef logic [15:0] cpu_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    HALTREQ,
    ALIGN,
    GET,
    PUT
  } dma_state_t;

  localparam cpu_addr_t NES_DMA_REG_ADDR  = 16'h4014;
  localparam cpu_addr_t NES_OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/nes_bus_mux.sv
// Bus-master select: CPU drives the bus unless the DMA engine owns it.
module nes_bus_mux
  import nes_bus_pkg::*;
(
  input  logic        i_sel_dma,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_ren,
  input  logic        i_cpu_wen,
  input  logic [7:0]  i_cpu_wdata,
  input  logic [15:0] i_dma_addr,
  input  logic        i_dma_ren,
  input  logic        i_dma_wen,
  input  logic [7:0]  i_dma_wdata,
  output logic [15:0] o_bus_addr,
  output logic        o_bus_ren,
  output logic        o_bus_wen,
  output logic [7:0]  o_bus_wdata
);

  cpu_addr_t w_addr;

  // CPU strobes are fully masked while the DMA owns the bus
  always_comb begin
    w_addr      = i_cpu_addr;
    o_bus_ren   = i_cpu_ren;
    o_bus_wen   = i_cpu_wen;
    o_bus_wdata = i_cpu_wdata;
    if (i_sel_dma) begin
      w_addr      = i_dma_addr;
      o_bus_ren   = i_dma_ren;
      o_bus_wen   = i_dma_wen;
      o_bus_wdata = i_dma_wdata;
    end
  end

  assign o_bus_addr = w_addr;

endmodule

// File: rtl/nes_oam_dma.sv
// Sprite DMA engine: a CPU write to $4014 halts the CPU via RDY and copies
// page $PP00-$PPFF to OAMDATA, one byte per get/put CPU-cycle pair.
module nes_oam_dma
  import nes_bus_pkg::*;
#(
  parameter cpu_addr_t DMA_REG_ADDR  = NES_DMA_REG_ADDR,
  parameter cpu_addr_t OAM_DATA_ADDR = NES_OAM_DATA_ADDR,
  parameter int        XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_en,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_ren,
  input  logic        cpu_wen,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic        bus_ren,
  output logic        bus_wen,
  output logic [7:0]  bus_wdata,
  output logic        dma_active
);

  localparam int               CNT_W    = $clog2(XFER_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(XFER_LEN - 1);

  dma_state_t       r_state;
  logic             r_parity;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_page;
  logic [7:0]       r_data;
  logic             r_cpu_rdy;
  logic             r_dma_active;
  cpu_addr_t        r_dma_addr;
  logic             r_dma_ren;
  logic             r_dma_wen;

  dma_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [7:0]       w_page_nxt;
  logic [7:0]       w_data_nxt;
  logic             w_cpu_rdy_nxt;
  logic             w_active_nxt;
  cpu_addr_t        w_dma_addr_nxt;
  logic             w_dma_ren_nxt;
  logic             w_dma_wen_nxt;
  logic             w_trigger;

  assign w_trigger = cpu_wen && (cpu_addr == DMA_REG_ADDR);

  // State register plus registered DMA-side bus drive; all advance only on CPU-cycle boundaries
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_parity     <= 1'b0;
      r_count      <= '0;
      r_page       <= '0;
      r_data       <= '0;
      r_cpu_rdy    <= 1'b1;
      r_dma_active <= 1'b0;
      r_dma_addr   <= '0;
      r_dma_ren    <= 1'b0;
      r_dma_wen    <= 1'b0;
    end else if (cyc_en) begin
      r_state      <= w_state_nxt;
      r_parity     <= ~r_parity;
      r_count      <= w_count_nxt;
      r_page       <= w_page_nxt;
      r_data       <= w_data_nxt;
      r_cpu_rdy    <= w_cpu_rdy_nxt;
      r_dma_active <= w_active_nxt;
      r_dma_addr   <= w_dma_addr_nxt;
      r_dma_ren    <= w_dma_ren_nxt;
      r_dma_wen    <= w_dma_wen_nxt;
    end
  end

  // Next state and the bus drive for the cycle that the next state represents
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_page_nxt  = r_page;
    w_data_nxt  = r_data;
    case (r_state)
      IDLE: begin
        if (w_trigger) begin
          w_page_nxt  = cpu_wdata;
          w_state_nxt = HALTREQ;
        end
      end
      HALTREQ: begin
        // The 6502 only honours RDY on reads; the first read is the halt cycle.
        // A halt on a put-parity cycle lands the next cycle on a get directly.
        if (cpu_ren) begin
          w_state_nxt = r_parity ? GET : ALIGN;
        end
      end
      ALIGN: begin
        w_state_nxt = GET;
      end
      GET: begin
        w_data_nxt  = bus_rdata;
        w_state_nxt = PUT;
      end
      PUT: begin
        if (r_count == LAST_IDX) begin
          w_count_nxt = '0;
          w_state_nxt = IDLE;
        end else begin
          w_count_nxt = r_count + 1'b1;
          w_state_nxt = GET;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // CPU is held off for every state except IDLE
    w_cpu_rdy_nxt  = (w_state_nxt == IDLE);
    w_active_nxt   = (w_state_nxt == GET) || (w_state_nxt == PUT);
    w_dma_ren_nxt  = (w_state_nxt == GET);
    w_dma_wen_nxt  = (w_state_nxt == PUT);
    w_dma_addr_nxt = OAM_DATA_ADDR;
    if (w_state_nxt == GET) begin
      w_dma_addr_nxt = cpu_addr_t'({w_page_nxt, 8'h00}) | cpu_addr_t'(w_count_nxt);
    end
  end

  nes_bus_mux u_mux (
    .i_sel_dma   (r_dma_active),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_ren   (cpu_ren),
    .i_cpu_wen   (cpu_wen),
    .i_cpu_wdata (cpu_wdata),
    .i_dma_addr  (r_dma_addr),
    .i_dma_ren   (r_dma_ren),
    .i_dma_wen   (r_dma_wen),
    .i_dma_wdata (r_data),
    .o_bus_addr  (bus_addr),
    .o_bus_ren   (bus_ren),
    .o_bus_wen   (bus_wen),
    .o_bus_wdata (bus_wdata)
  );

  assign cpu_rdy    = r_cpu_rdy;
  assign dma_active = r_dma_active;

endmodule

// File: tb/tb_nes_oam_dma.sv
// Self-checking bench for nes_oam_dma: idle pass-through vector table,
// directed and randomized full transfers checked against a transfer-level model.
module tb_nes_oam_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc_en;
  logic [15:0] cpu_addr;
  logic        cpu_ren;
  logic        cpu_wen;
  logic [7:0]  cpu_wdata;
  logic [7:0]  bus_rdata;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic        bus_ren;
  logic        bus_wen;
  logic [7:0]  bus_wdata;
  logic        dma_active;

  logic [7:0]  mem [0:65535];

  always #5 clk = ~clk;

  assign bus_rdata = mem[bus_addr];

  nes_oam_dma dut (
    .clk        (clk),
    .rst        (rst),
    .cyc_en     (cyc_en),
    .cpu_addr   (cpu_addr),
    .cpu_ren    (cpu_ren),
    .cpu_wen    (cpu_wen),
    .cpu_wdata  (cpu_wdata),
    .bus_rdata  (bus_rdata),
    .cpu_rdy    (cpu_rdy),
    .bus_addr   (bus_addr),
    .bus_ren    (bus_ren),
    .bus_wen    (bus_wen),
    .bus_wdata  (bus_wdata),
    .dma_active (dma_active)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit tb_par;

  logic        s_rdy, s_act, s_ren, s_wen;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [15:0] e_addr;
    logic        e_ren;
    logic        e_wen;
    logic [7:0]  e_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One CPU cycle: drive CPU outputs, snapshot bus state mid-cycle, end with a cyc_en edge
  task automatic cpu_cycle(input logic ren, input logic wen, input logic [15:0] a, input logic [7:0] d);
    cpu_ren   = ren;
    cpu_wen   = wen;
    cpu_addr  = a;
    cpu_wdata = d;
    cyc_en    = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    cyc_en = 1'b1;
    #1;
    s_rdy   = cpu_rdy;
    s_act   = dma_active;
    s_ren   = bus_ren;
    s_wen   = bus_wen;
    s_addr  = bus_addr;
    s_wdata = bus_wdata;
    @(negedge clk);
    cyc_en = 1'b0;
    tb_par = ~tb_par;
  endtask

  // Full transfer: trigger, optional CPU writes before the halt read, then halted reads until RDY returns
  task automatic run_xfer(input logic [7:0] page, input int pre, input int want_hp,
                          input int rst_at, input bit inject);
    logic [15:0] rq[$];
    logic [7:0]  wq[$];
    int          first_rd;
    int          halted;
    int          hpar;
    bit          hp;
    bit          done;
    logic [15:0] a;
    logic [7:0]  d;

    hpar = (int'(tb_par) + 1 + pre) % 2;
    if (want_hp >= 0 && hpar != want_hp) cpu_cycle(1'b0, 1'b0, 16'h0000, 8'h00);

    cpu_cycle(1'b0, 1'b1, 16'h4014, page);
    chk("trig_rdy_before", 32'(s_rdy), 32'd1);
    chk("trig_pass_addr", 32'(s_addr), 32'h4014);

    for (int k = 0; k < pre; k++) begin
      a = (inject && k == 0) ? 16'h4014 : 16'h6000 + 16'(k);
      d = inject ? 8'h05 : 8'(k);
      cpu_cycle(1'b0, 1'b1, a, d);
      chk("haltreq_rdy", 32'(s_rdy), 32'd0);
      chk("haltreq_no_dma", 32'(s_act), 32'd0);
      chk("haltreq_pass_wen", 32'(s_wen), 32'd1);
      chk("haltreq_pass_addr", 32'(s_addr), 32'(a));
    end

    hp       = tb_par;
    halted   = 0;
    first_rd = -1;
    done     = 1'b0;
    for (int h = 0; h < 600 && !done; h++) begin
      cpu_cycle(1'b1, 1'b0, 16'hC000, 8'h00);
      if (h == 0) begin
        chk("halt_cycle_rdy", 32'(s_rdy), 32'd0);
        chk("halt_cycle_pass", 32'(s_addr), 32'hC000);
      end
      if (s_rdy) begin
        done = 1'b1;
      end else begin
        halted++;
        if (s_act) chk("one_strobe", 32'(s_ren ^ s_wen), 32'd1);
        if (s_act && s_ren) begin
          if (first_rd < 0) first_rd = h;
          rq.push_back(s_addr);
        end
        if (s_act && s_wen) begin
          chk("wr_addr", 32'(s_addr), 32'h2004);
          wq.push_back(s_wdata);
        end
        if (rst_at >= 0 && wq.size() == rst_at) begin
          rst = 1'b1;
          @(negedge clk);
          rst    = 1'b0;
          tb_par = 1'b0;
          chk("rst_mid_rdy", 32'(cpu_rdy), 32'd1);
          chk("rst_mid_act", 32'(dma_active), 32'd0);
          for (int j = 0; j < 6; j++) begin
            cpu_cycle(1'b1, 1'b0, 16'hC000, 8'h00);
            chk("rst_mid_no_put", 32'(s_wen), 32'd0);
            chk("rst_mid_idle", 32'(s_act), 32'd0);
          end
          return;
        end
      end
    end

    chk("halt_done", 32'(done), 32'd1);
    chk("halt_len", 32'(halted), hp ? 32'd513 : 32'd514);
    chk("first_rd_cycle", 32'(first_rd), hp ? 32'd1 : 32'd2);
    chk("n_reads", 32'(rq.size()), 32'd256);
    chk("n_writes", 32'(wq.size()), 32'd256);
    for (int i = 0; i < rq.size(); i++)
      chk("rd_addr", 32'(rq[i]), 32'({page, 8'(i)}));
    for (int i = 0; i < wq.size(); i++)
      chk("wr_data", 32'(wq[i]), 32'(mem[{page, 8'(i)}]));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [6];

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    vt[0] = '{1'b0, 1'b1, 16'h2004, 8'hAA, 16'h2004, 1'b0, 1'b1, 8'hAA};
    vt[1] = '{1'b1, 1'b0, 16'h8000, 8'h00, 16'h8000, 1'b1, 1'b0, 8'h00};
    vt[2] = '{1'b0, 1'b1, 16'h4015, 8'h5A, 16'h4015, 1'b0, 1'b1, 8'h5A};
    vt[3] = '{1'b1, 1'b0, 16'h4014, 8'h33, 16'h4014, 1'b1, 1'b0, 8'h33};
    vt[4] = '{1'b0, 1'b1, 16'h4013, 8'hFF, 16'h4013, 1'b0, 1'b1, 8'hFF};
    vt[5] = '{1'b0, 1'b0, 16'h0000, 8'h12, 16'h0000, 1'b0, 1'b0, 8'h12};

    rst       = 1'b1;
    cyc_en    = 1'b0;
    cpu_ren   = 1'b0;
    cpu_wen   = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_rdy", 32'(cpu_rdy), 32'd1);
    chk("reset_act", 32'(dma_active), 32'd0);
    chk("reset_pass_addr", 32'(bus_addr), 32'h0000);
    chk("reset_pass_wen", 32'(bus_wen), 32'd0);
    rst    = 1'b0;
    tb_par = 1'b0;

    for (int i = 0; i < 6; i++) begin
      cpu_cycle(vt[i].ren, vt[i].wen, vt[i].addr, vt[i].wdata);
      chk("idle_addr", 32'(s_addr), 32'(vt[i].e_addr));
      chk("idle_ren", 32'(s_ren), 32'(vt[i].e_ren));
      chk("idle_wen", 32'(s_wen), 32'(vt[i].e_wen));
      chk("idle_wdata", 32'(s_wdata), 32'(vt[i].e_wdata));
      chk("idle_act", 32'(s_act), 32'd0);
      chk("idle_rdy", 32'(s_rdy), 32'd1);
    end

    run_xfer(8'h02, 0, 1, -1, 1'b0);
    run_xfer(8'h02, 0, 0, -1, 1'b0);
    run_xfer(8'h02, 3, -1, -1, 1'b0);
    run_xfer(8'h07, 0, -1, 100, 1'b0);
    run_xfer(8'h03, 1, -1, -1, 1'b0);
    run_xfer(8'h01, 2, -1, -1, 1'b1);
    run_xfer(8'h21, 0, -1, -1, 1'b0);

    // Reset coincident with a $4014 write wins: no halt follows
    cpu_ren   = 1'b0;
    cpu_wen   = 1'b1;
    cpu_addr  = 16'h4014;
    cpu_wdata = 8'h09;
    cyc_en    = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    cyc_en = 1'b0;
    tb_par = 1'b0;
    chk("rst_vs_trig_rdy", 32'(cpu_rdy), 32'd1);
    for (int j = 0; j < 3; j++) begin
      cpu_cycle(1'b1, 1'b0, 16'h8000, 8'h00);
      chk("rst_vs_trig_run_rdy", 32'(s_rdy), 32'd1);
      chk("rst_vs_trig_run_act", 32'(s_act), 32'd0);
    end

    for (int r = 0; r < 3; r++)
      run_xfer(8'($urandom), int'($urandom_range(0, 3)), -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nes_oam_dma.md
Name: nes_oam_dma

Overview:
- Sprite DMA engine on the NES CPU bus, directly downstream of the CPU core's address/strobe/data outputs.
- Watches CPU writes to $4014, then halts the CPU through RDY.
- Copies 256 bytes from CPU page $PP00-$PPFF to PPU OAMDATA ($2004), one byte per get/put CPU-cycle pair, as the 2A03 does.
- Owns the bus-master mux selecting CPU or DMA as the source of address, read/write and write data.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.
- XFER_LEN, 256, bytes per transfer (counter width = clog2(XFER_LEN)).

Ports:
- clk  in  1  system clock, the same clock that drives the CPU core.
- rst  in  1  synchronous, active-high reset.
- cyc_en  in  1  one-clk pulse per CPU cycle (phi2 rising edge resynchronised to clk).
- cpu_addr  in  16  CPU address output.
- cpu_ren  in  1  CPU read strobe.
- cpu_wen  in  1  CPU write strobe.
- cpu_wdata  in  8  CPU write data.
- bus_rdata  in  8  data returned by the bus for the current read.
- cpu_rdy  out  1  CPU ready; 0 halts the CPU on its next read cycle.
- bus_addr  out  16  muxed bus address.
- bus_ren  out  1  muxed read strobe.
- bus_wen  out  1  muxed write strobe.
- bus_wdata  out  8  muxed write data.
- dma_active  out  1  high while DMA owns the bus.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high.
- Reset values: state=IDLE, cpu_rdy=1, dma_active=0, parity=0, count=0, page=0, data latch=0. bus_* follow the CPU pass-through.
- Timing: all state, parity and counter updates happen only on clk edges where cyc_en=1. Outputs are registered.
- Parity: toggles on every cyc_en from reset. parity=0 is a get cycle, parity=1 is a put cycle.
- Trigger: cyc_en & cpu_wen & cpu_addr==DMA_REG_ADDR in IDLE latches page=cpu_wdata, drives cpu_rdy=0, and moves to HALTREQ.
- HALTREQ: waits for the first cycle with cpu_ren=1 (the 6502 ignores RDY on writes). That cycle becomes the halt cycle. Next state is ALIGN if the halt cycle has parity=0, otherwise GET. This gives 1 or 2 dummy cycles.
- ALIGN: one dummy cycle, then GET.
- GET: only entered on a get cycle. Drives bus_addr={page,count}, bus_ren=1, dma_active=1. Latches bus_rdata at the end of the cycle. Next state is PUT.
- PUT: drives bus_addr=OAM_DATA_ADDR, bus_wen=1, bus_wdata=latch. Then count+1.
  - If count was XFER_LEN-1: go to IDLE, cpu_rdy=1, dma_active=0.
  - Otherwise: go to GET.
- Total halt: 513 CPU cycles (even alignment) or 514 (odd), measured from the first halted read to the restoration of cpu_rdy.
- Pass-through: bus_* = cpu_* whenever dma_active=0. While dma_active=1 the CPU strobes are masked.
- Writes to $4014 while state!=IDLE are ignored. No restart, no page change.
- count is 8-bit; wrap-around after $FF is the termination condition. The source page never increments.
- Page $20-$3F is legal; no special casing.
- Reset mid-transfer: IDLE next clk, cpu_rdy=1, no further bus_wen to $2004.
- rst takes priority over a coincident trigger.

Decomposition:
- Shared package nes_bus_pkg holds:
  - typedef enum dma_state_t {IDLE, HALTREQ, ALIGN, GET, PUT};
  - constants for $4014 and $2004;
  - typedef cpu_addr_t (logic [15:0]).
- One sub-module, nes_bus_mux: a purely combinational CPU/DMA select for addr, ren, wen and wdata. The FSM, parity and counter stay in the top.

Test Plan:
- Write $4014=$02 with the halt read landing on parity=1 -> cpu_rdy=0 within 1 cycle; first bus read at $0200; 256 writes to $2004 with data = RAM[$0200+i]; cpu_rdy returns to 1 after exactly 513 cycles.
- Same trigger with the halt read on parity=0 -> exactly one ALIGN dummy cycle; total 514; first read address $0200.
- Trigger followed by 3 consecutive CPU write cycles -> cpu_rdy=0 but no DMA bus activity until the first cpu_ren=1 cycle; then normal sequence.
- Pulse rst after 100 bytes of a transfer from page $07 -> next clk cpu_rdy=1, dma_active=0, no further writes to $2004; a new $4014=$03 write then runs a complete transfer from $0300.
- CPU write to $4014=$05 while DMA from page $01 is active -> ignored; all 256 reads come from $0100-$01FF.
- Idle pass-through: CPU write $2004=$AA at $2004 -> bus_addr=$2004, bus_wen=1, bus_wdata=$AA, dma_active=0, cpu_rdy=1.
